ps2_scancode_decoder: RTL

Receives the raw PS/2 keyboard clock/data pair, deserializes 11-bit frames into bytes and strips the protocol prefixes (E0 extended, F0 break). It presents a held "currently pressed key" scancode to the downstream direction converter, which decodes the arrow-key flags from its 8-bit `dataIn`. The scancode reads 8'h00 when no key is held.

---
 rtl/ps2_scancode_decoder_pkg.sv | 34 +++
 rtl/ps2_frame_rx.sv | 135 +++++++++++++
 rtl/ps2_scancode_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants and state encodings for the PS/2 scancode decoder and
// the downstream direction converter.
package ps2_scancode_decoder_pkg;

  // Protocol prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // Arrow key base codes (E0-prefixed on the keyboard)
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    PR_NORMAL   = 2'd0,
    PR_GOT_E0   = 2'd1,
    PR_GOT_F0   = 2'd2,
    PR_GOT_E0F0 = 2'd3
  } proto_state_t;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw clock/data pair, detects
// falling edges and deserializes 11-bit frames (start, 8 data LSB first,
// odd parity, stop). Partial frames are dropped after TIMEOUT_CYCLES of
// inactivity.
//
// Output handshake: byte_ok is a one-cycle strobe with no backpressure;
// rx_byte is valid in the cycle byte_ok is high. rx_err is a one-cycle
// strobe and is never high together with byte_ok.
module ps2_frame_rx
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         byte_ok,
  output logic [7:0]   rx_byte,
  output logic         rx_err,
  output frame_state_t state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall, bit_in;
  logic [CW-1:0] idle_cnt;
  logic          timeout;

  frame_state_t  state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_ok, par_ok_n;
  logic          byte_ok_n, err_n;

  // Two-flop synchronizers preset high, plus a registered falling-edge strobe
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fall   <= 1'b0;
      bit_in <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      fall   <= clk_s3 & ~clk_s2;
      bit_in <= dat_s2;
    end
  end

  // The counter holds the number of consecutive edge-free cycles already seen
  assign timeout = (state != FR_IDLE) && !fall &&
                   (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: cleared in IDLE and on every edge, saturating
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= '0;
    end else if (state == FR_IDLE || fall) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CW'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= FR_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_ok  <= 1'b0;
      byte_ok <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_ok  <= par_ok_n;
      byte_ok <= byte_ok_n;
      rx_err  <= err_n;
    end
  end

  // Frame FSM next state: advances only on a detected falling edge
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_ok_n  = par_ok;
    byte_ok_n = 1'b0;
    err_n     = 1'b0;
    if (timeout) begin
      state_n = FR_IDLE;
      err_n   = 1'b1;
    end else if (fall) begin
      case (state)
        FR_IDLE: begin
          if (!bit_in) begin
            state_n   = FR_DATA;
            bit_cnt_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
        FR_DATA: begin
          shreg_n   = {bit_in, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = FR_PARITY;
        end
        FR_PARITY: begin
          par_ok_n = odd_parity_ok(shreg, bit_in);
          state_n  = FR_STOP;
        end
        FR_STOP: begin
          if (bit_in && par_ok) byte_ok_n = 1'b1;
          else                  err_n     = 1'b1;
          state_n = FR_IDLE;
        end
        default: state_n = FR_IDLE;
      endcase
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard scancode decoder: strips E0/F0 prefixes and holds the
// base code of the currently pressed key (8'h00 when none).
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [7:0]   scancode,
  output logic         extended,
  output logic         code_valid,
  output logic         frame_err,
  output frame_state_t frame_state,
  output proto_state_t proto_state
);

  logic         byte_ok;
  logic [7:0]   rx_byte;
  logic         rx_err;

  proto_state_t proto_n;
  logic [7:0]   scan_n;
  logic         ext_n;
  logic         cv_n;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk     (clk),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .byte_ok (byte_ok),
    .rx_byte (rx_byte),
    .rx_err  (rx_err),
    .state   (frame_state)
  );

  // Protocol FSM state and held-key output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_state <= PR_NORMAL;
      scancode    <= 8'h00;
      extended    <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      proto_state <= proto_n;
      scancode    <= scan_n;
      extended    <= ext_n;
      code_valid  <= cv_n;
      frame_err   <= rx_err;
    end
  end

  // Protocol FSM next state: prefixes move state, makes load, matching breaks clear
  always_comb begin
    proto_n = proto_state;
    scan_n  = scancode;
    ext_n   = extended;
    cv_n    = 1'b0;
    if (rx_err) begin
      proto_n = PR_NORMAL;
    end else if (byte_ok) begin
      case (proto_state)
        PR_NORMAL: begin
          if (rx_byte == PS2_EXT) begin
            proto_n = PR_GOT_E0;
          end else if (rx_byte == PS2_BREAK) begin
            proto_n = PR_GOT_F0;
          end else begin
            scan_n = rx_byte;
            ext_n  = 1'b0;
            cv_n   = 1'b1;
          end
        end
        PR_GOT_E0: begin
          if (rx_byte == PS2_BREAK) begin
            proto_n = PR_GOT_E0F0;
          end else if (rx_byte != PS2_EXT) begin
            scan_n  = rx_byte;
            ext_n   = 1'b1;
            cv_n    = 1'b1;
            proto_n = PR_NORMAL;
          end
        end
        PR_GOT_F0: begin
          if (rx_byte == scancode && !extended) begin
            scan_n = 8'h00;
            ext_n  = 1'b0;
            cv_n   = 1'b1;
          end
          proto_n = PR_NORMAL;
        end
        PR_GOT_E0F0: begin
          if (rx_byte == scancode && extended) begin
            scan_n = 8'h00;
            ext_n  = 1'b0;
            cv_n   = 1'b1;
          end
          proto_n = PR_NORMAL;
        end
        default: proto_n = PR_NORMAL;
      endcase
    end
  end

endmodule
